rf_writeback_arbiter: RTL and testbench

- Sole owner of the register file write port (write-address, write-data and write-enable).
- After reset, runs an init sweep that zeroes x1..x31 through the write port.
- Then arbitrates between two writeback requesters, the ALU/execute path and the load unit, using valid/ready handshakes and round-robin fairness.
- Drives the register file write port with a registered, one-cycle-latency write strobe. Writes to x0 never reach the register file.

---
 rtl/rf_writeback_arbiter_if.sv | 29 ++
 rtl/rf_writeback_arbiter.sv | 88 ++++++++
 tb/tb_rf_writeback_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bus: two valid/ready requesters (ALU, load) in, register file write port out.
interface rf_writeback_arbiter_if #(
  parameter int AW   = 5,
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            rf_we;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, rf_rd, rf_data, rf_we
  );

  // Requester / register file side
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, rf_rd, rf_data, rf_we
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Register file write-port owner: zero sweep of x1..x(NUM_REGS-1) after reset,
// then round-robin arbitration of ALU and load writebacks with a registered
// one-cycle write strobe. x0 writes are accepted but never strobed.
module rf_writeback_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int AW       = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rf_writeback_arbiter_if.slave bus,
  output logic                  o_init_done
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {SRC_ALU, SRC_LD} src_t;

  // idx carries one extra bit so the increment never wraps before the compare
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_REGS - 1);

  state_t          r_state, w_state_nxt;
  src_t            r_last;
  logic [AW:0]     r_idx;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_rd;
  logic [XLEN-1:0] r_rf_data;
  logic            r_init_done;

  logic            w_gnt_alu, w_gnt_ld, w_xfer;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state and grant; grant already implies valid, so a grant is a transfer
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_alu   = 1'b0;
    w_gnt_ld    = 1'b0;
    case (r_state)
      S_INIT: if (r_idx == LAST_IDX) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.alu_valid && (!bus.ld_valid || r_last == SRC_LD)) w_gnt_alu = 1'b1;
        else if (bus.ld_valid)                                   w_gnt_ld  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_xfer = w_gnt_alu | w_gnt_ld;
  assign w_rd   = w_gnt_ld ? bus.ld_rd   : bus.alu_rd;
  assign w_data = w_gnt_ld ? bus.ld_data : bus.alu_data;

  // Write port: sweep writes during INIT, granted writeback during RUN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= (AW+1)'(1);
      r_rf_we     <= 1'b0;
      r_rf_rd     <= '0;
      r_rf_data   <= '0;
      r_init_done <= 1'b0;
      r_last      <= SRC_LD;
    end else if (r_state == S_INIT) begin
      r_rf_we   <= 1'b1;
      r_rf_rd   <= r_idx[AW-1:0];
      r_rf_data <= '0;
      r_idx     <= r_idx + 1'b1;
      if (r_idx == LAST_IDX) r_init_done <= 1'b1;
    end else if (w_xfer) begin
      r_rf_rd   <= w_rd;
      r_rf_data <= w_data;
      r_rf_we   <= (w_rd != '0);
      r_last    <= w_gnt_ld ? SRC_LD : SRC_ALU;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  assign bus.alu_ready = w_gnt_alu;
  assign bus.ld_ready  = w_gnt_ld;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_rd     = r_rf_rd;
  assign bus.rf_data   = r_rf_data;
  assign o_init_done   = r_init_done;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: sweep checks, vector table with a write scoreboard,
// and hand sequences for mid-sweep reset and a request held across INIT.
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic init_done;
  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.AW(5), .XLEN(32)) bus ();

  rf_writeback_arbiter #(.NUM_REGS(32), .XLEN(32), .AW(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus.slave),
    .o_init_done (init_done)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register file model fed by the write port; x0 must never be strobed
  logic [31:0] rfm [0:31];
  initial for (int i = 0; i < 32; i++) rfm[i] = 32'h0;
  always @(posedge clk) if (bus.rf_we) rfm[bus.rf_rd] <= bus.rf_data;

  // Scoreboard: expected write pushed on handshake, compared one cycle later
  typedef struct {bit we; logic [4:0] rd; logic [31:0] data;} wr_t;
  wr_t q[$];
  bit  sb_en = 1'b0;

  always @(negedge clk) begin : mon
    wr_t e;
    if (sb_en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(bus.rf_we == e.we, "sb_we", 64'(bus.rf_we), 64'(e.we));
        if (e.we) begin
          chk(bus.rf_rd == e.rd, "sb_rd", 64'(bus.rf_rd), 64'(e.rd));
          chk(bus.rf_data == e.data, "sb_data", 64'(bus.rf_data), 64'(e.data));
        end
      end else begin
        chk(bus.rf_we == 1'b0, "sb_idle_we", 64'(bus.rf_we), 64'h0);
      end
      chk(!(bus.alu_ready && bus.ld_ready), "one_ready", {bus.alu_ready, bus.ld_ready}, 64'h0);
      if (bus.alu_valid && bus.alu_ready)
        q.push_back('{we: (bus.alu_rd != 5'd0), rd: bus.alu_rd, data: bus.alu_data});
      else if (bus.ld_valid && bus.ld_ready)
        q.push_back('{we: (bus.ld_rd != 5'd0), rd: bus.ld_rd, data: bus.ld_data});
    end
  end

  // Runs 40 cycles from just after reset release and checks the zero sweep
  task automatic sweep_check(input string tag);
    int n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.rf_we) begin
        chk(bus.rf_rd == 5'(n + 1) && bus.rf_data == 32'h0, {tag, "_wr"}, {bus.rf_rd, bus.rf_data}, 64'(n + 1));
        n++;
      end
      chk(init_done == (n == 31), {tag, "_done"}, 64'(init_done), 64'(n == 31));
      if (!init_done)
        chk(!bus.alu_ready && !bus.ld_ready, {tag, "_rdy"}, {bus.alu_ready, bus.ld_ready}, 64'h0);
    end
    chk(n == 31, {tag, "_count"}, 64'(n), 64'd31);
  endtask

  task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ld;
  endtask

  typedef struct {
    bit av; logic [4:0] ard; logic [31:0] ad;
    bit lv; logic [4:0] lrd; logic [31:0] ld;
    bit ear; bit elr;
  } vec_t;
  vec_t vecs [13];

  initial begin
    // last is LD out of reset, so the ALU wins the first contended cycle
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b1};
    vecs[4]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22,       1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22,       1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22,       1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22,       1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd0, 32'h12345678, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h12345678, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};

    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk(bus.rf_we == 1'b0 && bus.rf_rd == 5'd0 && bus.rf_data == 32'h0, "reset_rf",
        {bus.rf_we, bus.rf_rd, bus.rf_data}, 64'h0);
    chk(init_done == 1'b0, "reset_done", 64'(init_done), 64'h0);
    chk(!bus.alu_ready && !bus.ld_ready, "reset_rdy", {bus.alu_ready, bus.ld_ready}, 64'h0);
    rst = 1'b0;
    sweep_check("sweep");

    // Vector table under the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      #2;
      chk(bus.alu_ready == vecs[i].ear, $sformatf("vec%0d_alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].ear));
      chk(bus.ld_ready == vecs[i].elr, $sformatf("vec%0d_ld_ready", i), 64'(bus.ld_ready), 64'(vecs[i].elr));
      tick();
    end
    sb_en = 1'b0;
    q.delete();
    chk(rfm[0] == 32'h0, "x0_kept_zero", 64'(rfm[0]), 64'h0);
    chk(rfm[5] == 32'hDEADBEEF, "x5_written", 64'(rfm[5]), 64'hDEADBEEF);
    chk(rfm[31] == 32'hA5A5A5A5, "x31_written", 64'(rfm[31]), 64'hA5A5A5A5);

    // Reset at sweep cycle 10 restarts the sweep from x1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk(bus.rf_we && bus.rf_rd == 5'd10, "mid_sweep_pos", {bus.rf_we, bus.rf_rd}, {1'b1, 5'd10});
    rst = 1'b1;
    tick();
    chk(bus.rf_we == 1'b0 && init_done == 1'b0, "mid_reset", {bus.rf_we, init_done}, 64'h0);
    rst = 1'b0;
    sweep_check("resweep");

    // ALU request held through INIT is taken in the first RUN cycle
    rst = 1'b1;
    set_in(1, 5'd9, 32'h99, 0, 0, 0);
    tick();
    rst = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
        tick();
        if (init_done) seen = 1'b1;
        else chk(bus.alu_ready == 1'b0, "init_hold_rdy", 64'(bus.alu_ready), 64'h0);
      end
      chk(seen, "init_done_timeout", 64'(seen), 64'h1);
    end
    chk(bus.alu_ready == 1'b1, "first_run_rdy", 64'(bus.alu_ready), 64'h1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    chk(bus.rf_we && bus.rf_rd == 5'd9 && bus.rf_data == 32'h99, "first_run_wr",
        {bus.rf_we, bus.rf_rd, bus.rf_data}, {1'b1, 5'd9, 32'h99});
    tick();
    chk(bus.rf_we == 1'b0, "first_run_after", 64'(bus.rf_we), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
